pipelined_addsub: RTL
=====================

// Module: pipelined_addsub
// PURPOSE
//  Parametrised, pipelined N-bit adder/subtractor. Successor to the single-cycle registered Adder.
//  The carry chain is split into STAGES equal segments, with one pipeline register per segment.
//  Input and output use valid/ready handshakes with full backpressure.
//  Adds subtract mode and a signed-overflow flag. Sits between operand sources and the result
//  consumer in the datapath; sustains one operation per clock.
// PARAMETERS
//  WIDTH   32  operand/result width in bits; must be >= 1
//  STAGES  4   pipeline depth = carry segments; must be >= 1 and divide WIDTH exactly (SEG = WIDTH/STAGES)
// PORTS
//  TClk       in   1      clock, all state updates on rising edge
//  TRst       in   1      asynchronous reset, active-high
//  in_valid   in   1      operand beat present
//  in_ready   out  1      block can accept operand beat this cycle
//  ra         in   WIDTH  operand A
//  rb         in   WIDTH  operand B
//  cin        in   1      carry-in (add) / borrow-in (sub)
//  sub        in   1      0: add, 1: subtract
//  out_valid  out  1      result beat present
//  out_ready  in   1      consumer accepts result this cycle
//  Sum        out  WIDTH  result
//  Cout       out  1      carry-out (add) / NOT borrow-out (sub)
//  Ovf        out  1      two's-complement signed overflow
// BEHAVIOUR
//  - Arithmetic:
//    - sub=0: {Cout,Sum} = ra + rb + cin.
//    - sub=1: {Cout,Sum} = ra + ~rb + ~cin, i.e. ra - rb - cin; Cout=0 means a borrow occurred.
//    - Ovf = (A[MSB] == B'[MSB]) && (Sum[MSB] != A[MSB]), where B' is the effective (possibly inverted) rb.
//    - All results are modulo 2^WIDTH.
//  - Pipeline:
//    - Stage k (0..STAGES-1) computes Sum bits [k*SEG +: SEG] from the carry registered by stage k-1.
//      Stage 0 uses the effective carry-in.
//    - Upper operand bits, the stage's partial sum and the carry travel with each beat.
//  - Per-stage valid bit v[k]; stage k loads when (!v[k] || load[k+1]); for the last stage,
//    load[STAGES] = out_ready.
//  - in_ready = !v[0] || load[1] (combinational from state and out_ready; never from in_valid).
//  - Acceptance: operands are captured on the edge where in_valid && in_ready. Beats are never
//    dropped, duplicated or reordered.
//  - Latency: exactly STAGES cycles from accept edge to out_valid=1, provided out_ready was high throughout.
//  - Throughput: 1 beat/cycle while out_ready stays 1.
//  - Output hold: out_valid = v[STAGES-1]. While out_valid && !out_ready, Sum, Cout and Ovf hold stable.
//  - Stall: with out_ready low, the pipeline compacts bubbles and then holds STAGES beats.
//    in_ready drops only when all stages are full.
//  - Simultaneous events: when full and out_ready=1, an output handoff and an input accept occur on the same edge.
//  - Reset (TRst=1, async, also mid-operation):
//    - All v[k]=0 immediately, so out_valid=0 immediately.
//    - Sum=0, Cout=0, Ovf=0, in_ready=1 while in reset. All in-flight beats are discarded.
//    - No stale result appears after TRst deasserts.
//  - STAGES=1: degenerates to a single registered adder with a handshake (latency 1).
//  - Operand ports are don't-care when in_valid=0.
// TESTING  (WIDTH=32, STAGES=4 unless noted)
//  1. Assert TRst, release -> out_valid=0, Sum=0, Cout=0, Ovf=0, in_ready=1.
//  2. Add 0xFFFFFFFF + 0x00000001, cin=0, out_ready=1 -> after 4 cycles Sum=0x00000000, Cout=1, Ovf=0.
//  3. Add 0x7FFFFFFF + 0x00000001, cin=0 -> Sum=0x80000000, Cout=0, Ovf=1.
//  4. Sub 5 - 7, cin=0 -> Sum=0xFFFFFFFE, Cout=0, Ovf=0.
//     Sub 0x80000000 - 1 -> Sum=0x7FFFFFFF, Cout=1, Ovf=1.
//  5. out_ready=0, stream 6 beats:
//     - 4 beats are accepted, then in_ready=0 and the output holds steady.
//     - Raise out_ready -> results arrive in order, one per cycle, and the remaining 2 beats are accepted.
//  6. Assert TRst with 3 beats in flight -> out_valid falls without waiting for a clock edge.
//     After release, no result appears until a new beat is accepted.
//  Plus: 10k random beats with random in_valid/out_ready against a behavioural model, for WIDTH/STAGES = 32/4, 32/1, 8/8.

Source files
------------

// File: rtl/pipelined_addsub_if.sv
// Operand/result handshake bundle for pipelined_addsub.
// master = operand source + result consumer, slave = the adder/subtractor.
interface pipelined_addsub_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Sum;
  logic             Cout;
  logic             Ovf;

  modport master (
    output in_valid, ra, rb, cin, sub, out_ready,
    input  in_ready, out_valid, Sum, Cout, Ovf
  );

  modport slave (
    input  in_valid, ra, rb, cin, sub, out_ready,
    output in_ready, out_valid, Sum, Cout, Ovf
  );
endinterface

// File: rtl/pipelined_addsub.sv
// Pipelined WIDTH-bit adder/subtractor. The carry chain is cut into STAGES
// segments of SEG bits; each stage resolves one segment and registers it
// together with the carry and the full (effective) operands, which the later
// stages need for their own segments and for the signed-overflow flag.
// Valid/ready on both sides with full backpressure and bubble compaction.
module pipelined_addsub #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input logic              TClk,
  input logic              TRst,
  pipelined_addsub_if.slave bus
);

  localparam int SEG  = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;

  logic [STAGES-1:0] v_q, v_d;
  logic [STAGES-1:0] c_q, c_d;
  logic [STAGES-1:0] load;
  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  a_d [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  b_d [STAGES];
  logic [WIDTH-1:0]  s_q [STAGES];
  logic [WIDTH-1:0]  s_d [STAGES];

  // A stage may load when it is empty or some stage downstream (or the consumer) makes room.
  always_comb begin
    logic room;
    load = '0;
    room = bus.out_ready;
    for (int k = LAST; k >= 0; k--) begin
      room    = room | ~v_q[k];
      load[k] = room;
    end
  end

  // Per-stage segment add; stage 0 applies the subtract inversion to rb and cin.
  always_comb begin
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic [WIDTH-1:0] s_in;
    logic             c_in;
    logic             v_in;
    logic [SEG:0]     seg;
    int               kp;
    v_d  = v_q;
    c_d  = c_q;
    a_d  = a_q;
    b_d  = b_q;
    s_d  = s_q;
    a_in = '0;
    b_in = '0;
    s_in = '0;
    c_in = 1'b0;
    v_in = 1'b0;
    seg  = '0;
    kp   = 0;
    for (int k = 0; k < STAGES; k++) begin
      kp = (k > 0) ? k - 1 : 0;
      if (k == 0) begin
        a_in = bus.ra;
        b_in = bus.sub ? ~bus.rb : bus.rb;
        c_in = bus.cin ^ bus.sub;
        s_in = '0;
        v_in = bus.in_valid;
      end else begin
        a_in = a_q[kp];
        b_in = b_q[kp];
        c_in = c_q[kp];
        s_in = s_q[kp];
        v_in = v_q[kp];
      end
      seg = {1'b0, a_in[k*SEG +: SEG]} + {1'b0, b_in[k*SEG +: SEG]} + {{SEG{1'b0}}, c_in};
      if (load[k]) begin
        v_d[k]              = v_in;
        a_d[k]              = a_in;
        b_d[k]              = b_in;
        s_d[k]              = s_in;
        s_d[k][k*SEG +: SEG] = seg[SEG-1:0];
        c_d[k]              = seg[SEG];
      end
    end
  end

  // Pipeline registers; reset empties every stage and clears the result.
  always_ff @(posedge TClk or posedge TRst) begin
    if (TRst) begin
      v_q <= '0;
      c_q <= '0;
      a_q <= '{default: '0};
      b_q <= '{default: '0};
      s_q <= '{default: '0};
    end else begin
      v_q <= v_d;
      c_q <= c_d;
      a_q <= a_d;
      b_q <= b_d;
      s_q <= s_d;
    end
  end

  assign bus.in_ready  = load[0];
  assign bus.out_valid = v_q[LAST];
  assign bus.Sum       = s_q[LAST];
  assign bus.Cout      = c_q[LAST];
  assign bus.Ovf       = (a_q[LAST][WIDTH-1] == b_q[LAST][WIDTH-1]) &&
                         (s_q[LAST][WIDTH-1] != a_q[LAST][WIDTH-1]);

endmodule
